div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list (clock and reset first); the block SHALL provide exactly these ports:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous active-high reset
  aluc  input  5  ALU op code; 20=div, 21=divu, 22=rem, 23=remu; all other codes are non-divide
  srcA  input  32  dividend (rs1 data)
  srcB  input  32  divisor (rs2 data)
  divReady  output  1  result valid this cycle; releases PC hold
  divBusy  output  1  iteration in progress
  divResult  output  32  quotient or remainder

Function
REQ-003 States SHALL be IDLE, BUSY and DONE; state, counter and result SHALL be registered.
REQ-004 IDLE with aluc in 20..23 SHALL capture srcA, srcB and aluc at the clock edge and go to BUSY with counter=0.
REQ-005 IDLE with any other aluc SHALL remain in IDLE.
REQ-006 Signed ops (20, 22) SHALL divide operand magnitudes.
REQ-007 Signed ops SHALL negate the quotient when the operand signs differ.
REQ-008 Signed ops SHALL give the remainder the dividend's sign.
REQ-009 Unsigned ops (21, 23) SHALL use the operands as captured.
REQ-010 BUSY SHALL run a radix-2 restoring iteration, one quotient bit per cycle, 32 cycles (counter 0..31).
REQ-011 BUSY SHALL move to DONE after the iteration with counter=31.
REQ-012 In DONE, divReady SHALL be 1 for exactly one cycle and divResult SHALL show the quotient (20/21) or remainder (22/23); the next state SHALL be IDLE.
REQ-013 Latency SHALL be 34 cycles: the request cycle is cycle 1 and divReady is high in cycle 34.
REQ-014 divReady SHALL be decoded from the registered state only; it SHALL have no combinational path from aluc, srcA or srcB.
REQ-015 divBusy SHALL be 1 exactly in BUSY.
REQ-016 Operand or aluc changes after capture SHALL NOT affect the result, with the single exception in REQ-017.
REQ-017 If aluc leaves 20..23 during BUSY, the block SHALL abort to IDLE; divReady SHALL NOT assert and divResult SHALL be unchanged.
REQ-018 After DONE, a divide aluc seen in IDLE SHALL start a new operation, so back-to-back divides are supported.
REQ-019 Divide by zero (srcB=0) SHALL give quotient 0xFFFFFFFF for both div and divu.
REQ-020 Divide by zero SHALL give remainder = srcA for both rem and remu.
REQ-021 Signed overflow (srcA=0x80000000, srcB=0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-022 divResult SHALL hold its last DONE value outside DONE.

Reset
REQ-023 rst=1 SHALL force state=IDLE, counter=0, divReady=0, divBusy=0, divResult=0 immediately, with no clock needed.
REQ-024 Reset asserted mid-BUSY SHALL discard the operation.
REQ-025 After reset release, the first divide SHALL take the full latency.

Configuration
REQ-026 Macro DIV_FAST_PATH_EN SHALL control the special-case path.
REQ-027 With DIV_FAST_PATH_EN defined, divide-by-zero and signed overflow SHALL be detected at capture and go IDLE->DONE directly, with divReady high in cycle 2.
REQ-028 Without DIV_FAST_PATH_EN, all operations SHALL take 34 cycles and give the same results as REQ-019..REQ-021.

Verification
REQ-029 divu, srcA=100, srcB=7 -> divReady in cycle 34, divResult=14; remu with the same operands -> 2.
REQ-030 div, srcA=0xFFFFFFF9 (-7), srcB=2 -> divResult=0xFFFFFFFD (-3); rem -> 0xFFFFFFFF (-1).
REQ-031 divu, srcA=0x1234, srcB=0 -> divResult=0xFFFFFFFF; remu -> 0x1234.
REQ-032 The divide-by-zero case SHALL complete in cycle 2 with DIV_FAST_PATH_EN and in cycle 34 without it.
REQ-033 div, srcA=0x80000000, srcB=0xFFFFFFFF -> divResult=0x80000000; rem -> 0.
REQ-034 rst pulsed at BUSY counter=10 -> divReady=0, divBusy=0, divResult=0 at once; a new divu 9/3 afterwards -> 3 in cycle 34.
REQ-035 Two consecutive divu ops (50/5 then 81/9) -> divReady pulses in cycles 34 and 68, divResult 10 then 9; divBusy SHALL be 0 only in the IDLE and DONE cycles.

Source files
------------

// File: rtl/div_unit.sv
// Iterative 32-bit divider: radix-2 restoring, one quotient bit per cycle, 34-cycle latency.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow straight from capture.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  aluc,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        divReady,
    output logic        divBusy,
    output logic [31:0] divResult
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [4:0]  r_count;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic [31:0] r_result;
    logic        r_isRem;
    logic        r_negQ;
    logic        r_negR;

    logic        w_isDivOp;
    logic        w_signedOp;
    logic        w_isRemOp;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic        w_fastStart;
    logic [31:0] w_specialResult;

    logic [32:0] w_shift;
    logic        w_fits;
    logic [31:0] w_remNext;
    logic [31:0] w_quoNext;
    logic [31:0] w_qFinal;
    logic [31:0] w_rFinal;

    assign w_isDivOp  = (aluc >= 5'd20) && (aluc <= 5'd23);
    assign w_signedOp = ~aluc[0];
    assign w_isRemOp  = aluc[1];
    assign w_magA     = (w_signedOp && srcA[31]) ? (32'd0 - srcA) : srcA;
    assign w_magB     = (w_signedOp && srcB[31]) ? (32'd0 - srcB) : srcB;

`ifdef DIV_FAST_PATH_EN
    logic w_divByZero;
    logic w_overflow;
    assign w_divByZero     = (srcB == 32'd0);
    assign w_overflow      = w_signedOp && (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
    assign w_fastStart     = w_isDivOp && (w_divByZero || w_overflow);
    assign w_specialResult = w_divByZero ? (w_isRemOp ? srcA  : 32'hFFFF_FFFF)
                                         : (w_isRemOp ? 32'd0 : 32'h8000_0000);
`else
    assign w_fastStart     = 1'b0;
    assign w_specialResult = 32'd0;
`endif

    // The remainder stays below the divisor, so the difference always fits in 32 bits.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_fits    = (w_shift >= {1'b0, r_divisor});
    assign w_remNext = w_fits ? (w_shift[31:0] - r_divisor) : w_shift[31:0];
    assign w_quoNext = {r_quo[30:0], w_fits};
    assign w_qFinal  = r_negQ ? (32'd0 - w_quoNext) : w_quoNext;
    assign w_rFinal  = r_negR ? (32'd0 - w_remNext) : w_remNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_isDivOp) begin
                    w_nextState = w_fastStart ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!w_isDivOp) begin
                    w_nextState = IDLE;
                end else if (r_count == 5'd31) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A zero divisor keeps the quotient positive so div by zero reads as all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 5'd0;
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_result  <= 32'd0;
            r_isRem   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
        end else begin
            if (r_state == IDLE && w_isDivOp) begin
                r_count   <= 5'd0;
                r_quo     <= w_magA;
                r_rem     <= 32'd0;
                r_divisor <= w_magB;
                r_isRem   <= w_isRemOp;
                r_negQ    <= w_signedOp && (srcA[31] ^ srcB[31]) && (srcB != 32'd0);
                r_negR    <= w_signedOp && srcA[31];
                if (w_fastStart) begin
                    r_result <= w_specialResult;
                end
            end else if (r_state == BUSY && w_isDivOp) begin
                r_count <= r_count + 5'd1;
                r_quo   <= w_quoNext;
                r_rem   <= w_remNext;
                if (r_count == 5'd31) begin
                    r_result <= r_isRem ? w_rFinal : w_qFinal;
                end
            end
        end
    end

    assign divReady  = (r_state == DONE);
    assign divBusy   = (r_state == BUSY);
    assign divResult = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, special cases, abort and reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  aluc;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        divReady;
    logic        divBusy;
    logic [31:0] divResult;

    int errors = 0;
    int checks = 0;

`ifdef DIV_FAST_PATH_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 34;
`endif

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [6:0]  lat;
    } vec_t;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .aluc      (aluc),
        .srcA      (srcA),
        .srcB      (srcB),
        .divReady  (divReady),
        .divBusy   (divBusy),
        .divResult (divResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents an op in the current cycle (cycle 1) and waits a bounded time for divReady.
    task automatic doOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output int lat, output logic [31:0] res,
                        output int busyZero, output logic busyAtReady);
        int cyc;
        lat = -1;
        res = 'x;
        busyZero = 0;
        busyAtReady = 1'bx;
        aluc = op;
        srcA = a;
        srcB = b;
        cyc = 1;
        while (cyc < 80 && lat < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (scramble && cyc == 5) begin
                srcA = ~a;
                srcB = b + 32'd3;
                aluc = op ^ 5'd2;
            end
            if (divReady === 1'b1) begin
                lat = cyc;
                res = divResult;
                busyAtReady = divBusy;
            end else if (divBusy !== 1'b1) begin
                busyZero++;
            end
        end
    endtask

    task automatic settle();
        aluc = 5'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aluc = 5'd0;
        srcA = 32'd0;
        srcB = 32'd0;
        #1;
        checks++;
        if ({divReady, divBusy} !== 2'b00 || divResult !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b busy=%b result=%h expected 0 0 00000000",
                     divReady, divBusy, divResult);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({divReady, divBusy} !== 2'b00 || divResult !== 32'd0) begin
            errors++;
            $display("[TB] FAIL after_reset_idle: ready=%b busy=%b result=%h expected 0 0 00000000",
                     divReady, divBusy, divResult);
        end
    endtask

    task automatic test_non_divide();
        logic [4:0] codes [5];
        int bad;
        codes = '{5'd0, 5'd5, 5'd19, 5'd24, 5'd31};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            aluc = codes[i];
            srcA = 32'd100;
            srcB = 32'd7;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                #1;
                if (divBusy !== 1'b0 || divReady !== 1'b0 || divResult !== 32'd0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL non_divide_idle: %0d bad cycles expected 0", bad);
        end
        settle();
    endtask

    task automatic test_unsigned();
        vec_t v [4];
        int lat, bz;
        logic [31:0] res;
        logic bar;
        v[0] = '{5'd21, 32'd100,         32'd7,     32'd14,          7'd34};
        v[1] = '{5'd23, 32'd100,         32'd7,     32'd2,           7'd34};
        v[2] = '{5'd21, 32'hFFFF_FFF9,   32'd2,     32'h7FFF_FFFC,   7'd34};
        v[3] = '{5'd23, 32'hFFFF_FFFF,   32'h10,    32'hF,           7'd34};
        for (int i = 0; i < 4; i++) begin
            doOp(v[i].op, v[i].a, v[i].b, 1'b0, lat, res, bz, bar);
            checks++;
            if (res !== v[i].exp || lat != int'(v[i].lat)) begin
                errors++;
                $display("[TB] FAIL unsigned_%0d: result=%h cycle=%0d expected %h cycle %0d",
                         i, res, lat, v[i].exp, v[i].lat);
            end
            checks++;
            if (bz != 0 || bar !== 1'b0) begin
                errors++;
                $display("[TB] FAIL unsigned_busy_%0d: idleCycles=%0d busyAtReady=%b expected 0 0",
                         i, bz, bar);
            end
            settle();
            checks++;
            if (divResult !== v[i].exp || divReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL unsigned_hold_%0d: result=%h ready=%b expected %h 0",
                         i, divResult, divReady, v[i].exp);
            end
        end
    endtask

    task automatic test_signed();
        vec_t v [4];
        int lat, bz;
        logic [31:0] res;
        logic bar;
        v[0] = '{5'd20, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 7'd34};
        v[1] = '{5'd22, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 7'd34};
        v[2] = '{5'd20, 32'd20,        32'hFFFF_FFFD,  32'hFFFF_FFFA, 7'd34};
        v[3] = '{5'd22, 32'd20,        32'hFFFF_FFFD,  32'd2,         7'd34};
        for (int i = 0; i < 4; i++) begin
            doOp(v[i].op, v[i].a, v[i].b, 1'b0, lat, res, bz, bar);
            checks++;
            if (res !== v[i].exp || lat != int'(v[i].lat)) begin
                errors++;
                $display("[TB] FAIL signed_%0d: result=%h cycle=%0d expected %h cycle %0d",
                         i, res, lat, v[i].exp, v[i].lat);
            end
            settle();
        end
    endtask

    task automatic test_div_by_zero();
        vec_t v [4];
        int lat, bz;
        logic [31:0] res;
        logic bar;
        v[0] = '{5'd21, 32'h1234,      32'd0, 32'hFFFF_FFFF, 7'(SPECIAL_LAT)};
        v[1] = '{5'd23, 32'h1234,      32'd0, 32'h1234,      7'(SPECIAL_LAT)};
        v[2] = '{5'd20, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 7'(SPECIAL_LAT)};
        v[3] = '{5'd22, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 7'(SPECIAL_LAT)};
        for (int i = 0; i < 4; i++) begin
            doOp(v[i].op, v[i].a, v[i].b, 1'b0, lat, res, bz, bar);
            checks++;
            if (res !== v[i].exp || lat != int'(v[i].lat)) begin
                errors++;
                $display("[TB] FAIL div_by_zero_%0d: result=%h cycle=%0d expected %h cycle %0d",
                         i, res, lat, v[i].exp, v[i].lat);
            end
            settle();
        end
    endtask

    task automatic test_overflow();
        vec_t v [4];
        int lat, bz;
        logic [31:0] res;
        logic bar;
        v[0] = '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 7'(SPECIAL_LAT)};
        v[1] = '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         7'(SPECIAL_LAT)};
        v[2] = '{5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         7'd34};
        v[3] = '{5'd23, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 7'd34};
        for (int i = 0; i < 4; i++) begin
            doOp(v[i].op, v[i].a, v[i].b, 1'b0, lat, res, bz, bar);
            checks++;
            if (res !== v[i].exp || lat != int'(v[i].lat)) begin
                errors++;
                $display("[TB] FAIL overflow_%0d: result=%h cycle=%0d expected %h cycle %0d",
                         i, res, lat, v[i].exp, v[i].lat);
            end
            settle();
        end
    endtask

    // Operands and op code are disturbed mid-iteration; the captured values must win.
    task automatic test_operand_change();
        int lat, bz;
        logic [31:0] res;
        logic bar;
        doOp(5'd21, 32'd100, 32'd7, 1'b1, lat, res, bz, bar);
        checks++;
        if (res !== 32'd14 || lat != 34) begin
            errors++;
            $display("[TB] FAIL operand_change: result=%h cycle=%0d expected 0000000e cycle 34",
                     res, lat);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bz1, bz2;
        logic [31:0] res1, res2;
        logic bar1, bar2;
        doOp(5'd21, 32'd50, 32'd5, 1'b0, lat1, res1, bz1, bar1);
        doOp(5'd21, 32'd81, 32'd9, 1'b0, lat2, res2, bz2, bar2);
        checks++;
        if (lat1 != 34 || res1 !== 32'd10) begin
            errors++;
            $display("[TB] FAIL b2b_first: result=%h cycle=%0d expected 0000000a cycle 34",
                     res1, lat1);
        end
        checks++;
        if (lat2 < 0 || (lat1 + lat2 - 1) != 68 || res2 !== 32'd9) begin
            errors++;
            $display("[TB] FAIL b2b_second: result=%h cycle=%0d expected 00000009 cycle 68",
                     res2, (lat2 < 0) ? -1 : lat1 + lat2 - 1);
        end
        checks++;
        if (bz1 != 0 || bz2 != 1 || bar1 !== 1'b0 || bar2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_busy: idle1=%0d idle2=%0d busyAtReady=%b%b expected 0 1 00",
                     bz1, bz2, bar1, bar2);
        end
        settle();
    endtask

    task automatic test_abort();
        logic [31:0] prior;
        int readyCount;
        prior = divResult;
        readyCount = 0;
        aluc = 5'd21;
        srcA = 32'd100;
        srcB = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        aluc = 5'd0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (divReady === 1'b1) readyCount++;
        end
        checks++;
        if (readyCount != 0 || divResult !== prior || divBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: readyPulses=%0d result=%h busy=%b expected 0 %h 0",
                     readyCount, divResult, divBusy, prior);
        end
    endtask

    task automatic test_mid_busy_reset();
        int lat, bz;
        logic [31:0] res;
        logic bar;
        aluc = 5'd21;
        srcA = 32'd100;
        srcB = 32'd7;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({divReady, divBusy} !== 2'b00 || divResult !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_busy_reset: ready=%b busy=%b result=%h expected 0 0 00000000",
                     divReady, divBusy, divResult);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        doOp(5'd21, 32'd9, 32'd3, 1'b0, lat, res, bz, bar);
        checks++;
        if (res !== 32'd3 || lat != 34) begin
            errors++;
            $display("[TB] FAIL post_reset_op: result=%h cycle=%0d expected 00000003 cycle 34",
                     res, lat);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_non_divide();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_operand_change();
        test_back_to_back();
        test_abort();
        test_mid_busy_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
